// File: rtl/strobe_delay_sched_pkg.sv
// Shared types and helpers for the programmable strobe delay scheduler.
package strobe_delay_pkg;

   localparam int DLY_MIN = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [31:0] clamp_delay(input logic [31:0] value);
      return (value < 32'(DLY_MIN)) ? 32'(DLY_MIN) : value;
   endfunction

endpackage

// File: rtl/strobe_delay_sched_ts_fifo.sv
// Deadline FIFO: DEPTH entries of W-bit timestamps, head readable combinationally.
module ts_fifo
   import strobe_delay_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign count   = count_reg;
   assign head    = mem[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/strobe_delay_sched.sv
// Re-issues each input strobe a configurable number of cycles later by queueing
// absolute deadlines against a free-running timestamp counter.
module strobe_delay_sched
   import strobe_delay_pkg::*;
#(
   parameter int DLY_W   = 16,
   parameter int DEPTH   = 8,
   parameter int DLY_RST = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DLY_W-1:0]           cfg_delay,
   input  logic                       cfg_wr,
   output logic                       cfg_rej,
   output logic [DLY_W-1:0]           delay,
   input  logic                       in,
   output logic                       out,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       busy,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int PEND_W = $clog2(DEPTH+1);

   logic [DLY_W-1:0]  tcnt_reg;
   logic [DLY_W-1:0]  delay_reg;
   logic              out_reg;
   logic              cfg_rej_reg;
   logic              ovf_reg;
   state_t            state_reg;
   state_t            state_next;

   logic [DLY_W-1:0]  head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [PEND_W-1:0] fifo_count;

   logic              pop;
   logic              push_ok;
   logic              drop;
   logic              cfg_ok;

   // Pop one cycle ahead of the deadline so the registered out lands exactly on it.
   assign pop     = !fifo_empty && (head == tcnt_reg + DLY_W'(1));
   assign push_ok = in && (!fifo_full || pop);
   assign drop    = in && !push_ok;

   // A strobe stays pending until its out pulse has been issued.
   assign pending = fifo_count + PEND_W'(out_reg);
   assign cfg_ok  = cfg_wr && (pending == '0) && !in;

   ts_fifo #(
      .W     (DLY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .din   (tcnt_reg + delay_reg),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_reg    <= '0;
         delay_reg   <= DLY_W'(DLY_RST);
         out_reg     <= 1'b0;
         cfg_rej_reg <= 1'b0;
         ovf_reg     <= 1'b0;
         state_reg   <= IDLE;
      end else begin
         tcnt_reg    <= tcnt_reg + DLY_W'(1);
         out_reg     <= pop;
         cfg_rej_reg <= cfg_wr && !cfg_ok;
         state_reg   <= state_next;
         if (cfg_ok) begin
            delay_reg <= DLY_W'(clamp_delay(32'(cfg_delay)));
         end
         if (drop) begin
            ovf_reg <= 1'b1;
         end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   // RUN is left once the FIFO has drained and the final out pulse is in flight.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (push_ok) state_next = RUN;
         RUN:     if (fifo_empty && !push_ok) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign out      = out_reg;
   assign cfg_rej  = cfg_rej_reg;
   assign overflow = ovf_reg;
   assign delay    = delay_reg;
   assign busy     = (state_reg == RUN);

endmodule

// File: tb/tb_strobe_delay_sched.sv
// Bench for strobe_delay_sched: directed phases plus random traffic against a
// model that tracks each accepted strobe by its absolute emission cycle.
module tb_strobe_delay_sched;

   localparam int DW    = 10;
   localparam int DEPTH = 8;
   localparam int PW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] cfg_delay;
   logic          cfg_wr;
   logic          cfg_rej;
   logic [DW-1:0] delay;
   logic          in;
   logic          out;
   logic [PW-1:0] pending;
   logic          busy;
   logic          overflow;
   logic          clr_ovf;

   strobe_delay_sched #(
      .DLY_W   (DW),
      .DEPTH   (DEPTH),
      .DLY_RST (2)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_delay (cfg_delay),
      .cfg_wr    (cfg_wr),
      .cfg_rej   (cfg_rej),
      .delay     (delay),
      .in        (in),
      .out       (out),
      .pending   (pending),
      .busy      (busy),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int emit_q[$];
   int delay_m     = 2;
   bit ovf_m       = 1'b0;
   bit rej_m       = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      vectors++;
      assert (obs === 32'(exp)) else begin
         miscompares++;
         $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive inputs, advance the model, then check every output.
   task automatic step(input bit rst, input bit i_in, input bit wr, input int d, input bit clr);
      int  fifo_n;
      int  pend_now;
      int  exp_pend;
      bit  popping;
      bit  accept;
      bit  cfg_ok;
      bit  exp_out;
      reset     = rst;
      in        = i_in;
      cfg_wr    = wr;
      cfg_delay = DW'(d);
      clr_ovf   = clr;
      if (rst) begin
         emit_q.delete();
         delay_m = 2;
         ovf_m   = 1'b0;
         rej_m   = 1'b0;
      end else begin
         fifo_n   = 0;
         pend_now = 0;
         popping  = 1'b0;
         foreach (emit_q[i]) begin
            if (emit_q[i] >= cyc + 1) fifo_n++;
            if (emit_q[i] >= cyc) pend_now++;
            if (emit_q[i] == cyc + 1) popping = 1'b1;
         end
         cfg_ok = wr && (pend_now == 0) && !i_in;
         rej_m  = wr && !cfg_ok;
         accept = i_in && ((fifo_n < DEPTH) || popping);
         if (accept) emit_q.push_back(cyc + delay_m);
         if (i_in && !accept) ovf_m = 1'b1;
         else if (clr) ovf_m = 1'b0;
         if (cfg_ok) delay_m = (d < 2) ? 2 : d;
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_out  = 1'b0;
      exp_pend = 0;
      foreach (emit_q[i]) begin
         if (emit_q[i] == cyc) exp_out = 1'b1;
         if (emit_q[i] >= cyc) exp_pend++;
      end
      while (emit_q.size() > 0 && emit_q[0] < cyc) void'(emit_q.pop_front());
      chk("out", 32'(out), int'(exp_out));
      chk("pending", 32'(pending), exp_pend);
      chk("busy", 32'(busy), (exp_pend != 0) ? 1 : 0);
      chk("overflow", 32'(overflow), int'(ovf_m));
      chk("cfg_rej", 32'(cfg_rej), int'(rej_m));
      chk("delay", 32'(delay), delay_m);
      if (out === 1'b1) $display("cycle %0d: out pulse, pending=%0d", cyc, pending);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0);
   endtask

   task automatic strobe(input int n);
      repeat (n) step(0, 1, 0, 0, 0);
   endtask

   task automatic cfg(input int d);
      step(0, 0, 1, d, 0);
   endtask

   initial begin
      // Reset, then one strobe at the reset delay of 2.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(9);
      strobe(1);
      idle(5);

      // Long delay with a back-to-back burst.
      cfg(1000);
      idle(4);
      strobe(3);
      idle(1010);

      // Maximum delay; crosses the timestamp wrap.
      cfg(1023);
      strobe(2);
      idle(1030);

      // Overflow: ten strobes into eight slots; clear coincides with a drop, then clears alone.
      cfg(50);
      strobe(9);
      step(0, 1, 0, 0, 1);
      idle(3);
      step(0, 0, 0, 0, 1);
      idle(55);

      // Config refused while busy and when colliding with a strobe; small value clamps to 2.
      cfg(30);
      strobe(3);
      cfg(500);
      idle(35);
      cfg(0);
      step(0, 1, 1, 77, 0);
      idle(5);

      // Continuous input at delay 9 keeps the FIFO full with a pop every cycle.
      cfg(9);
      strobe(30);
      idle(15);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
              int'($urandom_range(0, 40)), ($urandom_range(0, 31) == 0));
      end
      idle(50);

      // Reset mid-flight flushes queued strobes.
      cfg(100);
      strobe(4);
      idle(5);
      step(1, 0, 0, 0, 0);
      idle(120);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
